// File: rtl/fifo_s_reader.sv
// fifo_s_reader: read-side drain engine for the fifo_s synchronous FIFO.
// Owns the FIFO read port (ren/empty/data_out) and presents the stored
// words downstream as a valid/ready stream. A 2-entry skid buffer hides
// the FIFO's one-cycle read latency so a word can leave every clock.
//
// Optional feature: define FIFO_S_READER_CNT_EN to add the 16-bit
// words_out delivered-word counter port. Without it there is no port and
// no counter logic; everything else is identical.
module fifo_s_reader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_ren,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef FIFO_S_READER_CNT_EN
  ,
  output logic [15:0]      words_out
`endif
);

  // Buffer state: entries held locally, a read in flight, head and tail.
  logic [1:0]       occ;
  logic             inflight;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;

  logic [1:0]       occ_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic [WIDTH-1:0] tail_nxt;
  logic [1:0]       committed;
  logic             pop;

  // Downstream side: head is always the oldest word, straight from a flop.
  assign m_valid = (occ != 2'd0);
  assign m_data  = head;
  assign pop     = m_valid & m_ready;

  // Slots already spoken for once this cycle's pop is taken out. A pop
  // implies occ >= 1, so the subtraction cannot wrap, and the invariant
  // occ + inflight <= 2 keeps the sum inside two bits.
  assign committed = occ + {1'b0, inflight} - {1'b0, pop};

  // Issue a read only when a slot will be free for the word it returns;
  // held low for the whole of reset so nothing is pulled from the FIFO.
  assign fifo_ren = !reset && !fifo_empty && (committed < 2'd2);

  // Next buffer contents: apply the pop first, then land the returning
  // word into the first free slot, which keeps FIFO order in every case.
  always_comb begin
    // NOTE: every variable gets a default before any branch, otherwise
    // the paths that do not assign it would infer a latch.
    occ_nxt  = occ;
    head_nxt = head;
    tail_nxt = tail;
    if (pop) begin
      head_nxt = tail;
      occ_nxt  = occ - 2'd1;
    end
    if (inflight) begin
      if (occ_nxt == 2'd0) begin
        head_nxt = fifo_data;
      end else begin
        tail_nxt = fifo_data;
      end
      occ_nxt = occ_nxt + 2'd1;
    end
  end

  // State register; reset discards buffered and in-flight words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      // NOTE: the data entries are reset too (unlike a plain storage
      // array) because m_data is driven straight from head and must read
      // zero during and right after reset.
      head     <= '0;
      tail     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      occ      <= occ_nxt;
      inflight <= fifo_ren;
      head     <= head_nxt;
      tail     <= tail_nxt;
    end
  end

`ifdef FIFO_S_READER_CNT_EN
  // Delivered-word counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      words_out <= 16'd0;
    end else if (pop) begin
      words_out <= words_out + 16'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // Never read from an empty FIFO.
  a_no_ren_when_empty : assert property (
    @(posedge clk) disable iff (reset) fifo_ren |-> !fifo_empty);

  // Buffer plus in-flight read never exceeds the two local slots.
  a_no_overflow : assert property (
    @(posedge clk) disable iff (reset)
    ({1'b0, occ} + {2'b00, inflight}) <= 3'd2);

  // A presented word is held until it is taken.
  a_valid_hold : assert property (
    @(posedge clk) disable iff (reset)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));
`endif

endmodule

// File: tb/tb_fifo_s_reader.sv
// Self-checking bench for fifo_s_reader. A behavioural fifo_s (queue with
// a registered empty flag and registered data_out) feeds the DUT; a
// monitor records every delivered word, and each test task compares what
// was delivered against the words it wrote, in write order.
module tb_fifo_s_reader;

  localparam int WIDTH = 8;

  logic             clk        = 1'b0;
  logic             reset      = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_data  = '0;
  logic             fifo_ren;
  logic             m_valid;
  logic             m_ready    = 1'b0;
  logic [WIDTH-1:0] m_data;
`ifdef FIFO_S_READER_CNT_EN
  logic [15:0]      words_out;
`endif

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] fifo_q[$];  // contents of the modelled fifo_s
  logic [WIDTH-1:0] wr_q[$];    // words written this cycle, stored at next edge
  logic [WIDTH-1:0] got_q[$];   // words delivered downstream
  int               got_cyc[$]; // cycle index of each delivery
  int               cycle = 0;
  int               ren_count = 0;
  int               ren_empty_viol = 0;

  fifo_s_reader #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_ren   (fifo_ren),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
`ifdef FIFO_S_READER_CNT_EN
    ,
    .words_out  (words_out)
`endif
  );

  always #5 clk = ~clk;

  // fifo_s model plus delivery monitor.
  always @(posedge clk) begin
    cycle++;
    if (fifo_ren) begin
      ren_count++;
      if (fifo_empty) ren_empty_viol++;
      if (fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
    end
    if (!reset && m_valid && m_ready) begin
      got_q.push_back(m_data);
      got_cyc.push_back(cycle);
    end
    while (wr_q.size() != 0) fifo_q.push_back(wr_q.pop_front());
    fifo_empty <= (fifo_q.size() == 0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic wait_got(input int n, input int budget, input string name);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (got_q.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: delivered %0d words, expected %0d", name, got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++; if (fifo_ren !== 1'b0) begin errors++; $display("FAIL reset_ren: got %b want 0", fifo_ren); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_data: got %0d want 0", m_data); end
`ifdef FIFO_S_READER_CNT_EN
    checks++; if (words_out !== 16'd0) begin errors++; $display("FAIL reset_words_out: got %0d want 0", words_out); end
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_streaming();
    logic [WIDTH-1:0] exp[$];
    exp = '{8'd10, 8'd5, 8'd6, 8'd7, 8'd89, 8'd125, 8'd3, 8'd9};
    @(negedge clk);
    clear_log();
    m_ready = 1'b1;
    foreach (exp[i]) wr_q.push_back(exp[i]);
    wait_got(exp.size(), 40, "stream");
    checks++;
    if (got_q.size() != exp.size()) begin
      errors++; $display("FAIL stream_count: got %0d want %0d", got_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp[i]) begin errors++; $display("FAIL stream_word[%0d]: got %0d want %0d", i, got_q[i], exp[i]); end
    end
    if (got_cyc.size() == exp.size()) begin
      checks++;
      if (got_cyc[exp.size()-1] - got_cyc[0] != exp.size() - 1) begin
        errors++; $display("FAIL stream_consecutive: span %0d cycles want %0d", got_cyc[exp.size()-1] - got_cyc[0], exp.size() - 1);
      end
    end
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL stream_end_valid: got %b want 0", m_valid); end
  endtask

  task automatic test_single();
    int k = 0;
    @(negedge clk);
    clear_log();
    m_ready = 1'b1;
    wr_q.push_back(8'd22);
    while (fifo_empty && k < 5) begin @(negedge clk); k++; end
    // Cycle N: fifo_empty has fallen; the read must issue in the same cycle.
    checks++; if (fifo_ren !== 1'b1) begin errors++; $display("FAIL single_ren_N: got %b want 1", fifo_ren); end
    @(negedge clk);
    // Word in flight: not yet visible, FIFO empty again, no further read.
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_inflight_valid: got %b want 0", m_valid); end
    checks++; if (fifo_ren !== 1'b0) begin errors++; $display("FAIL single_no_reread: got %b want 0", fifo_ren); end
    @(negedge clk);
    // Landed on the edge closing the in-flight cycle.
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", m_valid); end
    checks++; if (m_data !== 8'd22) begin errors++; $display("FAIL single_data: got %0d want 22", m_data); end
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b want 0", m_valid); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] exp[$];
    logic             seen = 1'b0;
    logic             unstable = 1'b0;
    logic [WIDTH-1:0] held = '0;
    exp = '{8'd10, 8'd5, 8'd6, 8'd7, 8'd89, 8'd125, 8'd3, 8'd9};
    @(negedge clk);
    clear_log();
    m_ready = 1'b0;
    ren_count = 0;
    foreach (exp[i]) wr_q.push_back(exp[i]);
    repeat (10) begin
      @(negedge clk);
      if (seen && (m_valid !== 1'b1 || m_data !== held)) unstable = 1'b1;
      if (!seen && m_valid === 1'b1) begin seen = 1'b1; held = m_data; end
    end
    checks++; if (ren_count != 2) begin errors++; $display("FAIL bp_ren_pulses: got %0d want 2", ren_count); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", m_valid); end
    checks++; if (m_data !== 8'd10) begin errors++; $display("FAIL bp_data: got %0d want 10", m_data); end
    checks++; if (unstable) begin errors++; $display("FAIL bp_stable: got unstable want stable"); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL bp_no_pop: got %0d pops want 0", got_q.size()); end
    m_ready = 1'b1;
    wait_got(exp.size(), 40, "bp_drain");
    for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp[i]) begin errors++; $display("FAIL bp_word[%0d]: got %0d want %0d", i, got_q[i], exp[i]); end
    end
  endtask

  task automatic test_alternating();
    logic [WIDTH-1:0] exp[$];
    int k = 0;
    for (int i = 0; i < 6; i++) exp.push_back(WIDTH'($urandom));
    @(negedge clk);
    clear_log();
    ren_empty_viol = 0;
    m_ready = 1'b1;
    foreach (exp[i]) wr_q.push_back(exp[i]);
    while (got_q.size() < 6 && k < 60) begin
      @(negedge clk);
      m_ready = ~m_ready;
      k++;
    end
    m_ready = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL alt_pops: got %0d want 6", got_q.size()); end
    for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp[i]) begin errors++; $display("FAIL alt_word[%0d]: got %0d want %0d", i, got_q[i], exp[i]); end
    end
    checks++; if (ren_empty_viol != 0) begin errors++; $display("FAIL alt_ren_on_empty: got %0d reads want 0", ren_empty_viol); end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] rem[$];
    int k = 0;
    @(negedge clk);
    clear_log();
    m_ready = 1'b1;
    for (int i = 0; i < 12; i++) wr_q.push_back(WIDTH'($urandom));
    while (got_q.size() < 3 && k < 20) begin @(negedge clk); k++; end
    reset = 1'b1;
    #1;
    checks++; if (fifo_ren !== 1'b0) begin errors++; $display("FAIL midrst_ren: got %b want 0", fifo_ren); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", m_valid); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL midrst_data: got %0d want 0", m_data); end
    repeat (2) @(negedge clk);
    rem = fifo_q;
    clear_log();
    reset = 1'b0;
    wait_got(rem.size(), 60, "midrst_drain");
    repeat (4) @(negedge clk);
    checks++;
    if (got_q.size() != rem.size()) begin errors++; $display("FAIL midrst_count: got %0d want %0d", got_q.size(), rem.size()); end
    for (int i = 0; i < rem.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== rem[i]) begin errors++; $display("FAIL midrst_word[%0d]: got %0d want %0d", i, got_q[i], rem[i]); end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      logic [WIDTH-1:0] exp[$];
      int bad = 0;
      int ready_pct = 30 + 30 * r;
      @(negedge clk);
      clear_log();
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 99) < 40) begin
          logic [WIDTH-1:0] w;
          w = WIDTH'($urandom);
          exp.push_back(w);
          wr_q.push_back(w);
        end
        m_ready = ($urandom_range(0, 99) < ready_pct);
        @(negedge clk);
      end
      m_ready = 1'b1;
      wait_got(exp.size(), exp.size() + 20, "rand_drain");
      checks++;
      if (got_q.size() != exp.size()) begin errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", r, got_q.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
        if (got_q[i] !== exp[i]) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rand_order[%0d]: got %0d misordered words want 0", r, bad); end
    end
  endtask

`ifdef FIFO_S_READER_CNT_EN
  task automatic test_counter();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_log();
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) wr_q.push_back(WIDTH'($urandom));
    wait_got(20, 60, "cnt_drain");
    @(negedge clk);
    checks++; if (words_out !== 16'd20) begin errors++; $display("FAIL cnt_20: got %0d want 20", words_out); end
    force dut.words_out = 16'hFFFF;
    @(negedge clk);
    release dut.words_out;
    clear_log();
    wr_q.push_back(8'd77);
    wait_got(1, 20, "cnt_wrap_drain");
    @(negedge clk);
    checks++; if (words_out !== 16'd0) begin errors++; $display("FAIL cnt_wrap: got %0d want 0", words_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_single();
    test_backpressure();
    test_alternating();
    test_reset_mid();
    test_random();
`ifdef FIFO_S_READER_CNT_EN
    test_counter();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
